// File: rtl/riscv_writeback_pkg.sv
// riscv_writeback_pkg: shared register-file sizing, load funct3 codes and the load queue entry layout
package riscv_writeback_pkg;
   localparam int REG_COUNT = 32;
   localparam int REG_W = $clog2(REG_COUNT);
   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;
   typedef struct packed {
      logic [REG_W-1:0] rd_index;
      logic [2:0]       funct3;
      logic [1:0]       addr_lo;
   } load_entry_t;
endpackage

// File: rtl/riscv_writeback_if.sv
// riscv_writeback_if: ALU result, load issue, memory response, hazard check and register-file write bundle
// master drives ALU/issue/response/check inputs; slave (the write-back stage) drives ready, stall, write port, count, error
interface riscv_writeback_if #(parameter int LOAD_DEPTH = 2);
   import riscv_writeback_pkg::*;
   logic                        alu_valid, alu_ready;
   logic [REG_W-1:0]            alu_rd_index;
   logic [31:0]                 alu_rd;
   logic                        load_issue_valid, load_issue_ready;
   logic [REG_W-1:0]            load_issue_rd_index;
   logic [2:0]                  load_issue_funct3;
   logic [1:0]                  load_issue_addr_lo;
   logic                        mem_rdata_valid;
   logic [31:0]                 mem_rdata;
   logic [REG_W-1:0]            check_rs1_index, check_rs2_index;
   logic                        stall;
   logic                        enable_write_rd;
   logic [REG_W-1:0]            rd_index;
   logic [31:0]                 rd;
   logic [$clog2(LOAD_DEPTH):0] pending_count;
   logic                        wb_error;
   modport master (
      output alu_valid, alu_rd_index, alu_rd, load_issue_valid, load_issue_rd_index, load_issue_funct3,
             load_issue_addr_lo, mem_rdata_valid, mem_rdata, check_rs1_index, check_rs2_index,
      input  alu_ready, load_issue_ready, stall, enable_write_rd, rd_index, rd, pending_count, wb_error
   );
   modport slave (
      input  alu_valid, alu_rd_index, alu_rd, load_issue_valid, load_issue_rd_index, load_issue_funct3,
             load_issue_addr_lo, mem_rdata_valid, mem_rdata, check_rs1_index, check_rs2_index,
      output alu_ready, load_issue_ready, stall, enable_write_rd, rd_index, rd, pending_count, wb_error
   );
endinterface

// File: rtl/riscv_load_queue.sv
// riscv_load_queue: in-order FIFO of outstanding loads with per-entry visibility for hazard checks
// ports: clock/reset (async active-low), push/pop with push_data; full, empty, count, head_data,
// entry_valid/entry_data expose every slot
module riscv_load_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 10
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       push_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head_data,
   output logic [DEPTH-1:0]       entry_valid,
   output logic [WIDTH-1:0]       entry_data [DEPTH]
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;
   // explicit wrap so non-power-of-two depths never index past the last slot
   function automatic logic [PW-1:0] wrap_inc(logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction
   assign full        = count_q == CW'(DEPTH);
   assign empty       = count_q == '0;
   assign push_ok     = push && !full;
   assign pop_ok      = pop && !empty;
   assign count       = count_q;
   assign head_data   = data_q[head_q];
   assign entry_valid = valid_q;
   assign entry_data  = data_q;
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (pop_ok) valid_d[head_q] = 1'b0;
      if (push_ok) begin
         data_d[tail_q]  = push_data;
         valid_d[tail_q] = 1'b1;
      end
      head_d  = pop_ok ? wrap_inc(head_q) : head_q;
      tail_d  = push_ok ? wrap_inc(tail_q) : tail_q;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/riscv_writeback.sv
// riscv_writeback: merges ALU results and in-order load responses into the register-file write port
// ports: clock, reset (async active-low), wb (slave side of riscv_writeback_if): ALU accept, load issue,
// memory response, decode hazard check/stall, registered write port, pending_count, sticky wb_error
module riscv_writeback
   import riscv_writeback_pkg::*;
#(
   parameter int LOAD_DEPTH = 2
) (
   input logic               clock,
   input logic               reset,
   riscv_writeback_if.slave  wb
);
   localparam int LW = $bits(load_entry_t);
   logic                        full, empty, push, pop, alu_take, bad_funct3, hit1, hit2;
   logic [$clog2(LOAD_DEPTH):0] count;
   logic [LW-1:0]               head_data;
   logic [LOAD_DEPTH-1:0]       entry_valid;
   logic [LW-1:0]               entry_data [LOAD_DEPTH];
   logic [REG_W-1:0]            entry_rd [LOAD_DEPTH];
   load_entry_t                 head;
   logic [7:0]                  byte_sel;
   logic [15:0]                 half_sel;
   logic [31:0]                 load_data;
   logic                        we_q, we_d, err_q, err_d;
   logic [REG_W-1:0]            rd_index_q, rd_index_d;
   logic [31:0]                 rd_q, rd_d;
   riscv_load_queue #(.DEPTH(LOAD_DEPTH), .WIDTH(LW)) u_queue (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .pop         (pop),
      .push_data   ({wb.load_issue_rd_index, wb.load_issue_funct3, wb.load_issue_addr_lo}),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .head_data   (head_data),
      .entry_valid (entry_valid),
      .entry_data  (entry_data)
   );
   for (genvar i = 0; i < LOAD_DEPTH; i++) begin : g_rd
      load_entry_t e;
      assign e           = load_entry_t'(entry_data[i]);
      assign entry_rd[i] = e.rd_index;
   end
   assign head                = load_entry_t'(head_data);
   // ready comes from the registered count, so a same-cycle pop never frees a slot early
   assign wb.load_issue_ready = !full;
   assign wb.alu_ready        = !wb.mem_rdata_valid;
   assign push                = wb.load_issue_valid && !full;
   assign pop                 = wb.mem_rdata_valid && !empty;
   assign alu_take            = wb.alu_valid && !wb.mem_rdata_valid;
   assign byte_sel            = 8'(wb.mem_rdata >> {head.addr_lo, 3'b000});
   assign half_sel            = head.addr_lo[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
   always_comb begin
      bad_funct3 = !(head.funct3 inside {LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU});
      load_data  = head.funct3 == LOAD_LB  ? {{24{byte_sel[7]}}, byte_sel} :
                   head.funct3 == LOAD_LH  ? {{16{half_sel[15]}}, half_sel} :
                   head.funct3 == LOAD_LBU ? {24'd0, byte_sel} :
                   head.funct3 == LOAD_LHU ? {16'd0, half_sel} : wb.mem_rdata;
      we_d       = pop ? head.rd_index != '0 : alu_take && wb.alu_rd_index != '0;
      rd_index_d = pop ? head.rd_index : alu_take ? wb.alu_rd_index : rd_index_q;
      rd_d       = pop ? load_data : alu_take ? wb.alu_rd : rd_q;
      err_d      = err_q || (wb.mem_rdata_valid && empty) || (pop && bad_funct3);
   end
   always_comb begin
      hit1 = we_q && rd_index_q == wb.check_rs1_index;
      hit2 = we_q && rd_index_q == wb.check_rs2_index;
      for (int i = 0; i < LOAD_DEPTH; i++) begin
         hit1 = hit1 || (entry_valid[i] && entry_rd[i] == wb.check_rs1_index);
         hit2 = hit2 || (entry_valid[i] && entry_rd[i] == wb.check_rs2_index);
      end
   end
   // x0 never holds a pending value, so it can never stall
   assign wb.stall = (hit1 && wb.check_rs1_index != '0) || (hit2 && wb.check_rs2_index != '0);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_q       <= 1'b0;
         rd_index_q <= '0;
         rd_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         we_q       <= we_d;
         rd_index_q <= rd_index_d;
         rd_q       <= rd_d;
         err_q      <= err_d;
      end
   end
   assign wb.enable_write_rd = we_q;
   assign wb.rd_index        = rd_index_q;
   assign wb.rd              = rd_q;
   assign wb.pending_count   = count;
   assign wb.wb_error        = err_q;
endmodule
